dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller.
- Sits between the MEM stage and the data memory RAM, which returns a 256-bit line per read and accepts byte/half/word writes.
- Refills whole lines on read miss, forwards every store to memory, and stalls the MEM stage through cpu_ready.

Parameters:
- LINES, 16: number of cache lines; power of two.
- INDEX_W, 4: log2(LINES).
- TAG_W, 23: 32 - INDEX_W - 5.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  request valid
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address; bits [1:0] ignored for lookup
- cpu_wdata  in  32  store data, already in low lanes for byte/half
- cpu_sel  in  2  byte_sel / half_word_sel / word_sel (shared define encodings)
- cpu_ready  out  1  request accepted this cycle when cpu_req & cpu_ready
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid
- cpu_rdata  out  32  load word
- mem_ce  out  1  memory read enable
- mem_rd_addr  out  32  line-aligned byte address {tag, index, 5'b0}
- mem_rd_data  in  256  line; word k at bits [32k+31:32k]; combinational from mem_ce/mem_rd_addr
- mem_wr_addr  out  32  store address
- mem_wr_data  out  32  store data
- mem_wr_sel  out  2  store size
- mem_we  out  1  store enable, one-cycle pulse

Behaviour:
- Address split: tag [31:9], index [8:5] (for default parameters), word [4:2].
- Storage: valid[LINES], tag[LINES], data[LINES] x 256 bits.
- States: IDLE, REFILL, RESP, WRITE.
- Reset values:
  - State is IDLE; all valid bits are 0.
  - cpu_rvalid = 0, cpu_rdata = 0, mem_ce = 0, mem_we = 0.
  - mem_rd_addr, mem_wr_addr, mem_wr_data, mem_wr_sel are all 0.
- cpu_ready = 1 only in IDLE.
- IDLE, load hit (valid & tag match):
  - cpu_rdata <= data[index] word [word]; cpu_rvalid = 1 the next cycle.
  - Stays in IDLE, so back-to-back hits give 1 load/cycle with 1-cycle latency.
- IDLE, load miss:
  - Latch the address and go to REFILL.
- REFILL (1 cycle):
  - mem_ce = 1, mem_rd_addr = line address.
  - At the clock edge: capture mem_rd_data into data[index], write tag, set valid; go to RESP.
- RESP:
  - cpu_rvalid = 1 with the requested word from the captured line; go to IDLE.
  - Total miss latency: 2 cycles after acceptance.
- IDLE, store:
  - Register mem_wr_addr/data/sel; go to WRITE.
  - On tag hit, update the cached word at the same acceptance edge, using the lanes the memory writes:
    - byte_sel: bits [7:0]
    - half_word_sel: bits [15:0]
    - word_sel: all 32 bits
  - Other sel values: no cache update.
  - Store miss: the cache is unchanged.
- WRITE (1 cycle):
  - mem_we = 1; go to IDLE.
  - mem_we is 0 in every other state.
- cpu_rvalid is 0 except in the cycles defined above.
- cpu_rdata holds its value when cpu_rvalid = 0.
- Read-after-write to the same line is coherent: the cache was updated at store acceptance, and the memory is written before the next refill can start.
- A reset asserted in REFILL, RESP or WRITE:
  - Aborts the operation, returns to IDLE and clears all valid bits.
  - No partial line is installed.
  - mem_we/mem_ce are 0 in the cycle after reset.
- Index aliasing: a refill overwrites the resident line (no dirty data, since the cache is write-through).

Optional Feature:
- DCACHE_PERF_EN defined adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - Both are reset to 0 and wrap at 2^32.
  - hit_cnt is incremented per accepted load hit; miss_cnt per accepted load miss.
  - Stores are not counted.
- Undefined: the ports and counters are absent, with no other behavioural change.

Decomposition:
- Shared define file (existing): DataAddrBus, DataBus, CacheLine, SmallMemNumlog2, byte_sel/half_word_sel/word_sel, WriteEnable, ReadDisable, ZeroWord.
- New constants for that file: DCACHE_LINES, DCACHE_INDEX_W, state encodings.
- One sub-module, dcache_line_store: valid/tag/data arrays with a combinational hit/word read port, a line-fill write port, and a lane-masked word write port.
- The FSM stays in dcache_ctrl.

Test Plan:
- Reset, then load 0x0000_0040 (miss), memory line word0 = 0xDEAD_BEEF -> mem_ce high for exactly 1 cycle with mem_rd_addr = 0x40; cpu_rvalid 2 cycles after accept; cpu_rdata = 0xDEAD_BEEF.
- Loads 0x44, 0x48, 0x4C back-to-back after that refill -> cpu_ready stays 1; one rvalid per cycle; mem_ce stays 0.
- Store word 0x1234_5678 to 0x44 (hit), then load 0x44 -> mem_we pulses once with wr_addr = 0x44; load returns 0x1234_5678 with no refill.
- Store byte 0xAB to 0x48 (hit, old word 0x1111_1111) -> cached word becomes 0x1111_11AB; mem_wr_sel = byte_sel.
- Load 0x240 (same index as 0x40, different tag) -> refill from 0x240; a subsequent load of 0x40 misses again.
- Assert rst during REFILL -> next cycle: IDLE, mem_ce = 0, cpu_rvalid = 0; a load of that address misses again.

Source files
------------

// File: rtl/dcache_ctrl_pkg.sv
// rtl/dcache_ctrl_pkg.sv - shared constants, store-size encodings and FSM states for the data cache
//
// Contents:
//   DATA_ADDR_BUS / DATA_BUS / CACHE_LINE  bus widths (32 / 32 / 256)
//   BYTE_SEL / HALF_WORD_SEL / WORD_SEL    2-bit store-size encodings shared with the data RAM
//   WRITE_ENABLE / READ_DISABLE / ZERO_WORD common control levels and reset word
//   DCACHE_LINES / DCACHE_INDEX_W          default cache geometry
//   dcache_state_e                         controller states
//   lane_mask()                            store-size to bit-lane mask
package dcache_ctrl_pkg;

    localparam int DATA_ADDR_BUS = 32;
    localparam int DATA_BUS      = 32;
    localparam int CACHE_LINE    = 256;

    localparam logic [1:0] BYTE_SEL      = 2'b00;
    localparam logic [1:0] HALF_WORD_SEL = 2'b01;
    localparam logic [1:0] WORD_SEL      = 2'b10;

    localparam logic                WRITE_ENABLE = 1'b1;
    localparam logic                READ_DISABLE = 1'b0;
    localparam logic [DATA_BUS-1:0] ZERO_WORD    = 32'h0000_0000;

    localparam int DCACHE_LINES   = 16;
    localparam int DCACHE_INDEX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_RESP   = 2'd2,
        ST_WRITE  = 2'd3
    } dcache_state_e;

    // Store data arrives already in the low lanes, so the mask is always
    // anchored at bit 0 regardless of the address byte offset.
    function automatic logic [DATA_BUS-1:0] lane_mask(input logic [1:0] sel);
        case (sel)
            BYTE_SEL:      return 32'h0000_00FF;
            HALF_WORD_SEL: return 32'h0000_FFFF;
            WORD_SEL:      return 32'hFFFF_FFFF;
            default:       return ZERO_WORD;
        endcase
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// rtl/dcache_line_store.sv - valid/tag/data arrays for the direct-mapped data cache
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset (clears valid bits only)
//   lk_index/lk_tag/lk_word      combinational lookup address
//   lk_hit, lk_data              lookup result: line valid with matching tag, selected word
//   fill_en/fill_index/fill_tag/fill_line  whole-line install (sets valid)
//   wr_en/wr_index/wr_word/wr_data/wr_mask lane-masked update of one cached word
module dcache_line_store
    import dcache_ctrl_pkg::*;
#(
    parameter int LINES   = DCACHE_LINES,
    parameter int INDEX_W = DCACHE_INDEX_W,
    parameter int TAG_W   = 32 - INDEX_W - 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_W-1:0]    lk_index,
    input  logic [TAG_W-1:0]      lk_tag,
    input  logic [2:0]            lk_word,
    output logic                  lk_hit,
    output logic [DATA_BUS-1:0]   lk_data,
    input  logic                  fill_en,
    input  logic [INDEX_W-1:0]    fill_index,
    input  logic [TAG_W-1:0]      fill_tag,
    input  logic [CACHE_LINE-1:0] fill_line,
    input  logic                  wr_en,
    input  logic [INDEX_W-1:0]    wr_index,
    input  logic [2:0]            wr_word,
    input  logic [DATA_BUS-1:0]   wr_data,
    input  logic [DATA_BUS-1:0]   wr_mask
);

    logic [LINES-1:0]      valid_q, valid_d;
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [TAG_W-1:0]      tag_d  [LINES];
    logic [CACHE_LINE-1:0] data_q [LINES];
    logic [CACHE_LINE-1:0] data_d [LINES];
    logic [DATA_BUS-1:0]   old_word;

    assign lk_hit  = valid_q[lk_index] && (tag_q[lk_index] == lk_tag);
    assign lk_data = data_q[lk_index][{lk_word, 5'b0} +: DATA_BUS];

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        data_d   = data_q;
        old_word = data_q[wr_index][{wr_word, 5'b0} +: DATA_BUS];
        if (fill_en) begin
            valid_d[fill_index] = 1'b1;
            tag_d[fill_index]   = fill_tag;
            data_d[fill_index]  = fill_line;
        end
        if (wr_en) begin
            data_d[wr_index][{wr_word, 5'b0} +: DATA_BUS] =
                (old_word & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    // A reset that lands on a fill edge leaves the line invalid, so a
    // half-finished refill is never visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data are qualified by valid and need no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped, write-through, no-write-allocate data cache controller
//
// Optional feature macro: DCACHE_PERF_EN adds hit_cnt/miss_cnt load counters.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata/cpu_sel  MEM-stage request
//   cpu_ready                         high only in IDLE; request taken on cpu_req & cpu_ready
//   cpu_rvalid/cpu_rdata              one-cycle load response; rdata holds otherwise
//   mem_ce/mem_rd_addr/mem_rd_data    line refill port (combinational 256-bit read)
//   mem_we/mem_wr_addr/mem_wr_data/mem_wr_sel  store forwarding port
//   hit_cnt/miss_cnt                  (DCACHE_PERF_EN only) accepted load hits / misses
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int LINES   = DCACHE_LINES,
    parameter int INDEX_W = DCACHE_INDEX_W,
    parameter int TAG_W   = 32 - INDEX_W - 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [DATA_ADDR_BUS-1:0] cpu_addr,
    input  logic [DATA_BUS-1:0]      cpu_wdata,
    input  logic [1:0]               cpu_sel,
    output logic                     cpu_ready,
    output logic                     cpu_rvalid,
    output logic [DATA_BUS-1:0]      cpu_rdata,
    output logic                     mem_ce,
    output logic [DATA_ADDR_BUS-1:0] mem_rd_addr,
    input  logic [CACHE_LINE-1:0]    mem_rd_data,
    output logic [DATA_ADDR_BUS-1:0] mem_wr_addr,
    output logic [DATA_BUS-1:0]      mem_wr_data,
    output logic [1:0]               mem_wr_sel,
    output logic                     mem_we
`ifdef DCACHE_PERF_EN
    ,
    output logic [31:0]              hit_cnt,
    output logic [31:0]              miss_cnt
`endif
);

    dcache_state_e              state_q, state_d;
    logic                       cpu_rvalid_q, cpu_rvalid_d;
    logic [DATA_BUS-1:0]        cpu_rdata_q, cpu_rdata_d;
    logic                       mem_ce_q, mem_ce_d;
    logic [DATA_ADDR_BUS-1:0]   mem_rd_addr_q, mem_rd_addr_d;
    logic [DATA_ADDR_BUS-1:0]   mem_wr_addr_q, mem_wr_addr_d;
    logic [DATA_BUS-1:0]        mem_wr_data_q, mem_wr_data_d;
    logic [1:0]                 mem_wr_sel_q, mem_wr_sel_d;
    logic                       mem_we_q, mem_we_d;
    logic [2:0]                 req_word_q, req_word_d;

    logic [INDEX_W-1:0]         cpu_index;
    logic [TAG_W-1:0]           cpu_tag;
    logic [2:0]                 cpu_word;
    logic                       lk_hit;
    logic [DATA_BUS-1:0]        lk_data;
    logic                       fill_en;
    logic                       wr_en;
    logic [DATA_BUS-1:0]        wr_mask;
    logic                       load_hit_acc;
    logic                       load_miss_acc;

    assign cpu_tag   = cpu_addr[DATA_ADDR_BUS-1 -: TAG_W];
    assign cpu_index = cpu_addr[5 +: INDEX_W];
    assign cpu_word  = cpu_addr[4:2];
    assign wr_mask   = lane_mask(cpu_sel);

    // During REFILL the line address register still holds the tag and
    // index of the miss, so it doubles as the fill address.
    dcache_line_store #(
        .LINES   (LINES),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_line_store (
        .clk        (clk),
        .rst        (rst),
        .lk_index   (cpu_index),
        .lk_tag     (cpu_tag),
        .lk_word    (cpu_word),
        .lk_hit     (lk_hit),
        .lk_data    (lk_data),
        .fill_en    (fill_en),
        .fill_index (mem_rd_addr_q[5 +: INDEX_W]),
        .fill_tag   (mem_rd_addr_q[DATA_ADDR_BUS-1 -: TAG_W]),
        .fill_line  (mem_rd_data),
        .wr_en      (wr_en),
        .wr_index   (cpu_index),
        .wr_word    (cpu_word),
        .wr_data    (cpu_wdata),
        .wr_mask    (wr_mask)
    );

    always_comb begin
        state_d       = state_q;
        cpu_rvalid_d  = 1'b0;
        cpu_rdata_d   = cpu_rdata_q;
        mem_ce_d      = READ_DISABLE;
        mem_rd_addr_d = mem_rd_addr_q;
        mem_wr_addr_d = mem_wr_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        mem_wr_sel_d  = mem_wr_sel_q;
        mem_we_d      = 1'b0;
        req_word_d    = req_word_q;
        cpu_ready     = 1'b0;
        fill_en       = 1'b0;
        wr_en         = 1'b0;
        load_hit_acc  = 1'b0;
        load_miss_acc = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_req) begin
                    if (cpu_we) begin
                        mem_wr_addr_d = cpu_addr;
                        mem_wr_data_d = cpu_wdata;
                        mem_wr_sel_d  = cpu_sel;
                        mem_we_d      = WRITE_ENABLE;
                        // No-write-allocate: only a resident line is touched,
                        // and an unknown size leaves it alone.
                        wr_en         = lk_hit && (wr_mask != ZERO_WORD);
                        state_d       = ST_WRITE;
                    end else if (lk_hit) begin
                        load_hit_acc = 1'b1;
                        cpu_rvalid_d = 1'b1;
                        cpu_rdata_d  = lk_data;
                    end else begin
                        load_miss_acc = 1'b1;
                        mem_ce_d      = 1'b1;
                        mem_rd_addr_d = {cpu_addr[DATA_ADDR_BUS-1:5], 5'b0};
                        req_word_d    = cpu_word;
                        state_d       = ST_REFILL;
                    end
                end
            end
            ST_REFILL: begin
                // The response word is taken straight from the incoming line,
                // which is the same data being installed at this edge.
                fill_en      = 1'b1;
                cpu_rvalid_d = 1'b1;
                cpu_rdata_d  = mem_rd_data[{req_word_q, 5'b0} +: DATA_BUS];
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cpu_rvalid_q  <= 1'b0;
            cpu_rdata_q   <= ZERO_WORD;
            mem_ce_q      <= READ_DISABLE;
            mem_rd_addr_q <= '0;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= ZERO_WORD;
            mem_wr_sel_q  <= 2'b00;
            mem_we_q      <= 1'b0;
            req_word_q    <= 3'd0;
        end else begin
            state_q       <= state_d;
            cpu_rvalid_q  <= cpu_rvalid_d;
            cpu_rdata_q   <= cpu_rdata_d;
            mem_ce_q      <= mem_ce_d;
            mem_rd_addr_q <= mem_rd_addr_d;
            mem_wr_addr_q <= mem_wr_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            mem_wr_sel_q  <= mem_wr_sel_d;
            mem_we_q      <= mem_we_d;
            req_word_q    <= req_word_d;
        end
    end

    assign cpu_rvalid  = cpu_rvalid_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign mem_ce      = mem_ce_q;
    assign mem_rd_addr = mem_rd_addr_q;
    assign mem_wr_addr = mem_wr_addr_q;
    assign mem_wr_data = mem_wr_data_q;
    assign mem_wr_sel  = mem_wr_sel_q;
    assign mem_we      = mem_we_q;

`ifdef DCACHE_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q + {31'b0, load_hit_acc};
        miss_cnt_d = miss_cnt_q + {31'b0, load_miss_acc};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    logic unused_acc;
    assign unused_acc = load_hit_acc ^ load_miss_acc;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed self-checking bench for dcache_ctrl
module tb_dcache_ctrl;
    import dcache_ctrl_pkg::*;

    logic          clk;
    logic          rst;
    logic          cpu_req;
    logic          cpu_we;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [1:0]    cpu_sel;
    logic          cpu_ready;
    logic          cpu_rvalid;
    logic [31:0]   cpu_rdata;
    logic          mem_ce;
    logic [31:0]   mem_rd_addr;
    logic [255:0]  mem_rd_data;
    logic [31:0]   mem_wr_addr;
    logic [31:0]   mem_wr_data;
    logic [1:0]    mem_wr_sel;
    logic          mem_we;
`ifdef DCACHE_PERF_EN
    logic [31:0]   hit_cnt;
    logic [31:0]   miss_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    int we_pulses = 0;
    int we_before;
    logic load_mem;

    logic [31:0] mem [0:1023];

    dcache_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_sel     (cpu_sel),
        .cpu_ready   (cpu_ready),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .mem_ce      (mem_ce),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_sel  (mem_wr_sel),
        .mem_we      (mem_we)
`ifdef DCACHE_PERF_EN
        ,
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data RAM model: 4 KB, combinational line read, sized byte/half/word writes.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            mem_rd_data[32*k +: 32] = mem[{mem_rd_addr[11:5], 3'(k)}];
        end
    end

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[16]  <= 32'hDEAD_BEEF;
            mem[17]  <= 32'h2222_2222;
            mem[18]  <= 32'h1111_1111;
            mem[19]  <= 32'h3333_3333;
            mem[24]  <= 32'h6060_6060;
            mem[144] <= 32'hCAFE_F00D;
        end else if (mem_we) begin
            we_pulses <= we_pulses + 1;
            case (mem_wr_sel)
                BYTE_SEL:      mem[mem_wr_addr[11:2]][7:0]  <= mem_wr_data[7:0];
                HALF_WORD_SEL: mem[mem_wr_addr[11:2]][15:0] <= mem_wr_data[15:0];
                WORD_SEL:      mem[mem_wr_addr[11:2]]       <= mem_wr_data;
                default: ;
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] sel);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_sel   = sel;
    endtask

    task automatic load_miss(input logic [31:0] addr, input logic [31:0] line, input logic [31:0] exp);
        issue(1'b0, addr, 32'h0, WORD_SEL);
        @(negedge clk);
        cpu_req = 1'b0;
        exp_misses++;
        check_eq("miss mem_ce", 32'(mem_ce), 32'd1);
        check_eq("miss rd_addr", mem_rd_addr, line);
        check_eq("miss early rvalid", 32'(cpu_rvalid), 32'd0);
        check_eq("miss ready", 32'(cpu_ready), 32'd0);
        @(negedge clk);
        check_eq("resp mem_ce", 32'(mem_ce), 32'd0);
        check_eq("resp rvalid", 32'(cpu_rvalid), 32'd1);
        check_eq("resp rdata", cpu_rdata, exp);
        @(negedge clk);
        check_eq("post resp rvalid", 32'(cpu_rvalid), 32'd0);
        check_eq("post resp ready", 32'(cpu_ready), 32'd1);
    endtask

    task automatic load_hit(input logic [31:0] addr, input logic [31:0] exp);
        issue(1'b0, addr, 32'h0, WORD_SEL);
        @(negedge clk);
        cpu_req = 1'b0;
        exp_hits++;
        check_eq("hit rvalid", 32'(cpu_rvalid), 32'd1);
        check_eq("hit rdata", cpu_rdata, exp);
        check_eq("hit mem_ce", 32'(mem_ce), 32'd0);
        check_eq("hit ready", 32'(cpu_ready), 32'd1);
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] sel,
                         input logic [31:0] exp_mem);
        we_before = we_pulses;
        issue(1'b1, addr, wdata, sel);
        @(negedge clk);
        cpu_req = 1'b0;
        check_eq("store mem_we", 32'(mem_we), 32'd1);
        check_eq("store wr_addr", mem_wr_addr, addr);
        check_eq("store wr_data", mem_wr_data, wdata);
        check_eq("store wr_sel", 32'(mem_wr_sel), 32'(sel));
        check_eq("store ready", 32'(cpu_ready), 32'd0);
        @(negedge clk);
        check_eq("store mem_we drop", 32'(mem_we), 32'd0);
        check_eq("store ready back", 32'(cpu_ready), 32'd1);
        check_eq("store we pulses", 32'(we_pulses - we_before), 32'd1);
        check_eq("store mem word", mem[addr[11:2]], exp_mem);
    endtask

    initial begin
        rst       = 1'b1;
        load_mem  = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
        cpu_sel   = WORD_SEL;
        repeat (2) @(negedge clk);
        load_mem = 1'b0;

        check_eq("rst ready", 32'(cpu_ready), 32'd1);
        check_eq("rst rvalid", 32'(cpu_rvalid), 32'd0);
        check_eq("rst rdata", cpu_rdata, 32'h0);
        check_eq("rst mem_ce", 32'(mem_ce), 32'd0);
        check_eq("rst mem_we", 32'(mem_we), 32'd0);
        check_eq("rst rd_addr", mem_rd_addr, 32'h0);
        check_eq("rst wr_addr", mem_wr_addr, 32'h0);
        check_eq("rst wr_data", mem_wr_data, 32'h0);
        check_eq("rst wr_sel", 32'(mem_wr_sel), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        load_miss(32'h40, 32'h40, 32'hDEAD_BEEF);

        // Back-to-back hits on the freshly filled line.
        issue(1'b0, 32'h44, 32'h0, WORD_SEL);
        @(negedge clk);
        check_eq("b2b rdata 44", cpu_rdata, 32'h2222_2222);
        check_eq("b2b rvalid 44", 32'(cpu_rvalid), 32'd1);
        check_eq("b2b ready 44", 32'(cpu_ready), 32'd1);
        issue(1'b0, 32'h48, 32'h0, WORD_SEL);
        @(negedge clk);
        check_eq("b2b rdata 48", cpu_rdata, 32'h1111_1111);
        check_eq("b2b rvalid 48", 32'(cpu_rvalid), 32'd1);
        check_eq("b2b mem_ce 48", 32'(mem_ce), 32'd0);
        issue(1'b0, 32'h4C, 32'h0, WORD_SEL);
        @(negedge clk);
        check_eq("b2b rdata 4c", cpu_rdata, 32'h3333_3333);
        check_eq("b2b rvalid 4c", 32'(cpu_rvalid), 32'd1);
        cpu_req = 1'b0;
        exp_hits += 3;
        @(negedge clk);
        check_eq("idle rvalid", 32'(cpu_rvalid), 32'd0);
        check_eq("rdata hold", cpu_rdata, 32'h3333_3333);

        store(32'h44, 32'h1234_5678, WORD_SEL, 32'h1234_5678);
        load_hit(32'h44, 32'h1234_5678);
        store(32'h48, 32'hCCCC_CCAB, BYTE_SEL, 32'h1111_11AB);
        load_hit(32'h48, 32'h1111_11AB);
        store(32'h4C, 32'h9999_C0DE, HALF_WORD_SEL, 32'h3333_C0DE);
        load_hit(32'h4C, 32'h3333_C0DE);
        store(32'h44, 32'hFFFF_FFFF, 2'b11, 32'h1234_5678);
        load_hit(32'h44, 32'h1234_5678);

        // Store miss: memory updated, cache not allocated.
        store(32'h80, 32'h0BAD_F00D, WORD_SEL, 32'h0BAD_F00D);
        load_miss(32'h80, 32'h80, 32'h0BAD_F00D);

        // Index aliasing: 0x240 evicts 0x40.
        load_miss(32'h240, 32'h240, 32'hCAFE_F00D);
        load_miss(32'h40, 32'h40, 32'hDEAD_BEEF);
        load_hit(32'h48, 32'h1111_11AB);

        // Reset during REFILL.
        issue(1'b0, 32'h60, 32'h0, WORD_SEL);
        @(negedge clk);
        cpu_req = 1'b0;
        check_eq("abort mem_ce", 32'(mem_ce), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
        check_eq("abort mem_ce low", 32'(mem_ce), 32'd0);
        check_eq("abort rvalid", 32'(cpu_rvalid), 32'd0);
        check_eq("abort mem_we", 32'(mem_we), 32'd0);
        check_eq("abort ready", 32'(cpu_ready), 32'd1);
        load_miss(32'h60, 32'h60, 32'h6060_6060);
        load_miss(32'h40, 32'h40, 32'hDEAD_BEEF);
        load_hit(32'h40, 32'hDEAD_BEEF);

`ifdef DCACHE_PERF_EN
        check_eq("hit_cnt", hit_cnt, 32'(exp_hits));
        check_eq("miss_cnt", miss_cnt, 32'(exp_misses));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
